// File: rtl/execute_pkg.sv
// execute_pkg
//   Shared definitions for the execute stage slice.
//   - alu_op_e    : 3-bit ALU operation codes
//   - FWD_*       : forwarding-select encodings for the operand muxes
//   The XOR/SLL/SRL codes only do anything when ALU_EXT_OPS_EN is defined.
//   Otherwise the ALU returns 0 for them.
package execute_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_op_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/execute_cycle_alu.sv
// alu
//   Combinational XLEN-wide ALU used by the execute stage.
//   Arithmetic wraps modulo 2^XLEN.
//   Ports:
//     a, b   in  XLEN  operands
//     ctrl   in  3     operation select (execute_pkg::alu_op_e)
//     result out XLEN  operation result
//     zero   out 1     high when result is all zeros
//   Macro ALU_EXT_OPS_EN enables XOR, SLL and SRL (shift amount b[4:0]).
//   Without it, those codes return 0 and no shifter is built.
module alu
  import execute_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      ctrl,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  // Operation decode; unlisted or disabled codes fall through to zero
  always_comb begin
    result = '0;
    case (alu_op_e'(ctrl))
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      // SLT yields 1 or 0 in the low bit only
      ALU_SLT: result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
`ifdef ALU_EXT_OPS_EN
      ALU_XOR: result = a ^ b;
      ALU_SLL: result = a << b[4:0];
      ALU_SRL: result = a >> b[4:0];
`endif
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/execute_cycle.sv
// execute_cycle
//   Execute stage of a 5-stage pipeline, plus the E-to-M pipeline register.
//   - Forwarding muxes select each operand from one of three sources:
//     the register file, the writeback result, or the registered ALU result.
//   - The ALU source-B mux, the ALU itself and the branch-target adder.
//   - Branch decision (PCSrcE) and branch target (PCTargetE) are
//     combinational outputs.
//   Ports:
//     clk, rst          clock and asynchronous active-high reset
//     *E inputs         E-stage controls, operands, PC, forwarding selects
//     ResultW           writeback result (forwarding source)
//     PCSrcE, PCTargetE combinational branch outputs
//     *M outputs        registered controls and data for the M stage
//   Macro ALU_EXT_OPS_EN (passed through to alu) enables XOR/SLL/SRL.
module execute_cycle
  import execute_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic            ResultSrcE,
  input  logic            BranchE,
  input  logic            ALUSrcE,
  input  logic [2:0]      ALUControlE,
  input  logic [XLEN-1:0] RD1_E,
  input  logic [XLEN-1:0] RD2_E,
  input  logic [XLEN-1:0] Imm_Ext_E,
  input  logic [REGW-1:0] RD_E,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [XLEN-1:0] ResultW,
  input  logic [1:0]      ForwardA_E,
  input  logic [1:0]      ForwardB_E,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic            ResultSrcM,
  output logic [REGW-1:0] RD_M,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] ALU_ResultM
);

  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] alu_result;
  logic            alu_zero;

  // Forwarding muxes. FWD_MEM feeds back the registered ALU result, so
  // there is no combinational loop. Code 11 is unused and falls back to
  // the register file.
  always_comb begin
    case (ForwardA_E)
      FWD_WB:  src_a = ResultW;
      FWD_MEM: src_a = ALU_ResultM;
      default: src_a = RD1_E;
    endcase
    case (ForwardB_E)
      FWD_WB:  fwd_b = ResultW;
      FWD_MEM: fwd_b = ALU_ResultM;
      default: fwd_b = RD2_E;
    endcase
  end

  assign src_b = ALUSrcE ? Imm_Ext_E : fwd_b;

  alu #(
    .XLEN(XLEN)
  ) u_alu (
    .a     (src_a),
    .b     (src_b),
    .ctrl  (ALUControlE),
    .result(alu_result),
    .zero  (alu_zero)
  );

  assign PCSrcE    = BranchE & alu_zero;
  assign PCTargetE = PCE + Imm_Ext_E;

  // E-to-M register. There is no stall or enable. Reset clears it
  // asynchronously, which drops any instruction that is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWriteM   <= 1'b0;
      MemWriteM   <= 1'b0;
      ResultSrcM  <= 1'b0;
      RD_M        <= '0;
      PCPlus4M    <= '0;
      WriteDataM  <= '0;
      ALU_ResultM <= '0;
    end else begin
      RegWriteM   <= RegWriteE;
      MemWriteM   <= MemWriteE;
      ResultSrcM  <= ResultSrcE;
      RD_M        <= RD_E;
      PCPlus4M    <= PCPlus4E;
      WriteDataM  <= fwd_b;
      ALU_ResultM <= alu_result;
    end
  end

endmodule

// File: tb/tb_execute_cycle.sv
// tb_execute_cycle
//   Self-checking bench for execute_cycle.
//   Directed scenarios are followed by a randomized run. The randomized run
//   is checked against an arithmetic reference model of the execute stage.
module tb_execute_cycle;

  localparam int XLEN = 32;
  localparam int REGW = 5;

  logic            clk;
  logic            rst;
  logic            RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE;
  logic [2:0]      ALUControlE;
  logic [XLEN-1:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
  logic [REGW-1:0] RD_E;
  logic [1:0]      ForwardA_E, ForwardB_E;
  logic            PCSrcE;
  logic [XLEN-1:0] PCTargetE;
  logic            RegWriteM, MemWriteM, ResultSrcM;
  logic [REGW-1:0] RD_M;
  logic [XLEN-1:0] PCPlus4M, WriteDataM, ALU_ResultM;

  int n_compared = 0;
  int n_mismatch = 0;

  // Model state: the ALU result the M register should hold right now
  logic [XLEN-1:0] exp_alu_m;

  execute_cycle #(.XLEN(XLEN), .REGW(REGW)) dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .RD_E(RD_E),
    .PCE(PCE), .PCPlus4E(PCPlus4E), .ResultW(ResultW),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM),
    .ALU_ResultM(ALU_ResultM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU. It is written from the operation definitions.
  // SUB uses two's-complement addition. SLT compares sign bits first and
  // then the magnitudes.
  function automatic logic [XLEN-1:0] ref_alu(input logic [2:0] op,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    logic lt;
    ref_alu = '0;
    case (op)
      3'd0: ref_alu = a + b;
      3'd1: ref_alu = a + (~b) + 1;
      3'd2: ref_alu = a & b;
      3'd3: ref_alu = a | b;
      3'd5: begin
        if (a[XLEN-1] != b[XLEN-1]) lt = a[XLEN-1];
        else                        lt = (a < b);
        ref_alu = lt ? 1 : 0;
      end
`ifdef ALU_EXT_OPS_EN
      3'd4: ref_alu = a ^ b;
      3'd6: ref_alu = a << b[4:0];
      3'd7: ref_alu = a >> b[4:0];
`endif
      default: ref_alu = '0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] ref_fwd(input logic [1:0] sel,
                                              input logic [XLEN-1:0] rf,
                                              input logic [XLEN-1:0] wb,
                                              input logic [XLEN-1:0] mem);
    if (sel == 2'd1)      ref_fwd = wb;
    else if (sel == 2'd2) ref_fwd = mem;
    else                  ref_fwd = rf;
  endfunction

  task automatic clear_inputs();
    RegWriteE = 0; MemWriteE = 0; ResultSrcE = 0; BranchE = 0; ALUSrcE = 0;
    ALUControlE = 3'd0; RD1_E = '0; RD2_E = '0; Imm_Ext_E = '0; RD_E = '0;
    PCE = '0; PCPlus4E = '0; ResultW = '0; ForwardA_E = 2'd0; ForwardB_E = 2'd0;
  endtask

  task automatic randomize_inputs();
    RegWriteE = 1'($urandom); MemWriteE = 1'($urandom);
    ResultSrcE = 1'($urandom); BranchE = 1'($urandom); ALUSrcE = 1'($urandom);
    ALUControlE = 3'($urandom); RD1_E = $urandom; RD2_E = $urandom;
    Imm_Ext_E = $urandom; RD_E = REGW'($urandom); PCE = $urandom;
    PCPlus4E = PCE + 4; ResultW = $urandom;
    ForwardA_E = 2'($urandom); ForwardB_E = 2'($urandom);
  endtask

  // Reset holds every M output at zero before any clock edge, and keeps it
  // there across an edge. The combinational outputs still follow their inputs.
  task automatic test_reset();
    rst = 1'b1;
    randomize_inputs();
    #3;
    if ({RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM} !== '0) begin
      $display("[TB] FAIL reset_async: got %h/%h/%h rd=%h, required all zero",
               PCPlus4M, WriteDataM, ALU_ResultM, RD_M);
      n_mismatch++;
    end
    n_compared++;
    if (PCTargetE !== PCE + Imm_Ext_E) begin
      $display("[TB] FAIL reset_pctarget: got %h required %h", PCTargetE, PCE + Imm_Ext_E);
      n_mismatch++;
    end
    n_compared++;
    @(posedge clk); #1;
    if ({RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM} !== '0) begin
      $display("[TB] FAIL reset_held: alu=%h wd=%h, required zero", ALU_ResultM, WriteDataM);
      n_mismatch++;
    end
    n_compared++;
    rst = 1'b0;
    exp_alu_m = '0;
  endtask

  task automatic test_add_fwd_a();
    clear_inputs();
    ALUControlE = 3'b000; ALUSrcE = 1; ForwardA_E = 2'b01; ResultW = 32'h8;
    Imm_Ext_E = 32'h10; PCE = 32'h20; PCPlus4E = 32'h24; RD_E = 5'd1; RegWriteE = 1;
    RD1_E = 32'h1234_5678;
    #1;
    if (PCTargetE !== 32'h30) begin
      $display("[TB] FAIL add_pctarget: got %h required 30", PCTargetE);
      n_mismatch++;
    end
    n_compared++;
    @(posedge clk); #1;
    if (ALU_ResultM !== 32'h18 || RD_M !== 5'd1 || PCPlus4M !== 32'h24 || RegWriteM !== 1'b1) begin
      $display("[TB] FAIL add_capture: alu=%h rd=%h pc4=%h rw=%b required 18/1/24/1",
               ALU_ResultM, RD_M, PCPlus4M, RegWriteM);
      n_mismatch++;
    end
    n_compared++;
    exp_alu_m = 32'h18;
  endtask

  task automatic test_sub_fwd_m();
    ALUControlE = 3'b001; ForwardA_E = 2'b10; Imm_Ext_E = 32'h10; PCE = 32'h30; RD_E = 5'd2;
    #1;
    if (PCTargetE !== 32'h40) begin
      $display("[TB] FAIL sub_pctarget: got %h required 40", PCTargetE);
      n_mismatch++;
    end
    n_compared++;
    @(posedge clk); #1;
    if (ALU_ResultM !== 32'h08 || RD_M !== 5'd2) begin
      $display("[TB] FAIL sub_mem_fwd: alu=%h rd=%h required 8/2", ALU_ResultM, RD_M);
      n_mismatch++;
    end
    n_compared++;
    exp_alu_m = 32'h08;
  endtask

  task automatic test_branch();
    clear_inputs();
    BranchE = 1; ALUControlE = 3'b001; ALUSrcE = 0; RD1_E = 32'd7; RD2_E = 32'd7;
    #1;
    if (PCSrcE !== 1'b1) begin
      $display("[TB] FAIL branch_taken: got %b required 1", PCSrcE);
      n_mismatch++;
    end
    n_compared++;
    RD2_E = 32'd8;
    #1;
    if (PCSrcE !== 1'b0) begin
      $display("[TB] FAIL branch_not_taken: got %b required 0", PCSrcE);
      n_mismatch++;
    end
    n_compared++;
    @(posedge clk); #1;
    if (ALU_ResultM !== 32'hFFFF_FFFF) begin
      $display("[TB] FAIL branch_sub_wrap: got %h required ffffffff", ALU_ResultM);
      n_mismatch++;
    end
    n_compared++;
    exp_alu_m = 32'hFFFF_FFFF;
  endtask

  task automatic test_store_fwd_b();
    clear_inputs();
    MemWriteE = 1; ALUSrcE = 1; ForwardB_E = 2'b01; ResultW = 32'hDEAD_BEEF;
    RD1_E = 32'h100; RD2_E = 32'h5555_5555; Imm_Ext_E = 32'h4;
    @(posedge clk); #1;
    if (WriteDataM !== 32'hDEAD_BEEF || MemWriteM !== 1'b1 || ALU_ResultM !== 32'h104) begin
      $display("[TB] FAIL store_fwd_b: wd=%h mw=%b alu=%h required deadbeef/1/104",
               WriteDataM, MemWriteM, ALU_ResultM);
      n_mismatch++;
    end
    n_compared++;
    exp_alu_m = 32'h104;
  endtask

  task automatic test_slt_signed();
    clear_inputs();
    ALUControlE = 3'b101; RD1_E = 32'hFFFF_FFFF; RD2_E = 32'd1;
    @(posedge clk); #1;
    if (ALU_ResultM !== 32'd1) begin
      $display("[TB] FAIL slt_neg_lt_pos: got %h required 1", ALU_ResultM);
      n_mismatch++;
    end
    n_compared++;
    RD1_E = 32'd1; RD2_E = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    if (ALU_ResultM !== 32'd0) begin
      $display("[TB] FAIL slt_pos_lt_neg: got %h required 0", ALU_ResultM);
      n_mismatch++;
    end
    n_compared++;
    exp_alu_m = '0;
  endtask

  // A mid-cycle reset discards the pending instruction. Capture resumes on
  // the first edge after release.
  task automatic test_reset_mid_op();
    clear_inputs();
    RegWriteE = 1; RD_E = 5'd9; PCPlus4E = 32'h404; RD1_E = 32'h11; RD2_E = 32'h22;
    #2; rst = 1'b1; #1;
    if ({RegWriteM, RD_M, PCPlus4M, ALU_ResultM} !== '0) begin
      $display("[TB] FAIL reset_mid_op: rw=%b rd=%h alu=%h required zero", RegWriteM, RD_M, ALU_ResultM);
      n_mismatch++;
    end
    n_compared++;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_alu_m = '0;
    @(posedge clk); #1;
    if (ALU_ResultM !== 32'h33 || RD_M !== 5'd9 || PCPlus4M !== 32'h404) begin
      $display("[TB] FAIL reset_resume: alu=%h rd=%h pc4=%h required 33/9/404", ALU_ResultM, RD_M, PCPlus4M);
      n_mismatch++;
    end
    n_compared++;
    exp_alu_m = 32'h33;
  endtask

  task automatic test_random();
    logic [XLEN-1:0] a, fb, b, r;
    for (int i = 0; i < 300; i++) begin
      randomize_inputs();
      if ($urandom_range(0, 3) == 0) RD2_E = RD1_E;
      a  = ref_fwd(ForwardA_E, RD1_E, ResultW, exp_alu_m);
      fb = ref_fwd(ForwardB_E, RD2_E, ResultW, exp_alu_m);
      b  = ALUSrcE ? Imm_Ext_E : fb;
      r  = ref_alu(ALUControlE, a, b);
      #1;
      if (PCTargetE !== PCE + Imm_Ext_E || PCSrcE !== (BranchE && (r == '0))) begin
        $display("[TB] FAIL rand_comb[%0d]: tgt=%h src=%b required %h/%b", i,
                 PCTargetE, PCSrcE, PCE + Imm_Ext_E, (BranchE && (r == '0)));
        n_mismatch++;
      end
      n_compared++;
      @(posedge clk); #1;
      if (ALU_ResultM !== r || WriteDataM !== fb) begin
        $display("[TB] FAIL rand_data[%0d] op=%0d: alu=%h wd=%h required %h/%h", i,
                 ALUControlE, ALU_ResultM, WriteDataM, r, fb);
        n_mismatch++;
      end
      n_compared++;
      if ({RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M} !==
          {RegWriteE, MemWriteE, ResultSrcE, RD_E, PCPlus4E}) begin
        $display("[TB] FAIL rand_ctrl[%0d]: rw/mw/rs=%b%b%b rd=%h pc4=%h required %b%b%b/%h/%h", i,
                 RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M,
                 RegWriteE, MemWriteE, ResultSrcE, RD_E, PCPlus4E);
        n_mismatch++;
      end
      n_compared++;
      exp_alu_m = r;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    test_reset();
    test_add_fwd_a();
    test_sub_fwd_m();
    test_branch();
    test_store_fwd_b();
    test_slt_signed();
    test_reset_mid_op();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
